// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-master round-robin arbiter ahead of the SRAM debouncer, with
//            an in-order routing FIFO that steers each response to its issuer.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_wbe,
    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_resp_valid,
    input  logic                    m0_resp_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_wbe,
    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_resp_valid,
    input  logic                    m1_resp_ready,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic                    s_we,
    output logic [DATA_WIDTH/8-1:0] s_wbe,
    output logic                    s_req_valid,
    input  logic                    s_req_ready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic                    s_resp_valid,
    output logic                    s_resp_ready
);

    localparam int PTR_WIDTH = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_WIDTH = $clog2(OUTSTANDING + 1);

    localparam logic [CNT_WIDTH-1:0] C_MAX_COUNT = CNT_WIDTH'(OUTSTANDING);
    localparam logic [PTR_WIDTH-1:0] C_LAST_PTR  = PTR_WIDTH'(OUTSTANDING - 1);

    localparam logic [0:0] ST_OPEN   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic                   w_locked;
    logic                   r_locked_id;
    logic                   r_last_granted;

    logic [OUTSTANDING-1:0] r_fifo;
    logic [PTR_WIDTH-1:0]   r_wr_ptr;
    logic [PTR_WIDTH-1:0]   r_rd_ptr;
    logic [CNT_WIDTH-1:0]   r_count;

    logic                   w_sel;
    logic                   w_sel_valid;
    logic                   w_can_issue;
    logic                   w_s_req_valid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_head;
    logic                   w_s_resp_ready;
    logic [PTR_WIDTH-1:0]   w_wr_ptr_next;
    logic [PTR_WIDTH-1:0]   w_rd_ptr_next;

    // A pop in the same cycle does not free a slot: only the registered count counts.
    assign w_can_issue = (r_count < C_MAX_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_head      = r_fifo[r_rd_ptr];

    always_comb begin
        w_sel = 1'b0;
        if (w_locked) begin
            w_sel = r_locked_id;
        end else if (m0_req_valid && m1_req_valid) begin
            w_sel = ~r_last_granted;
        end else if (m1_req_valid) begin
            w_sel = 1'b1;
        end
    end

    assign w_sel_valid   = w_sel ? m1_req_valid : m0_req_valid;
    assign w_s_req_valid = w_can_issue && w_sel_valid;
    assign w_push        = w_s_req_valid && s_req_ready;

    assign s_req_valid  = w_s_req_valid;
    assign s_addr       = w_sel ? m1_addr  : m0_addr;
    assign s_wdata      = w_sel ? m1_wdata : m0_wdata;
    assign s_we         = w_sel ? m1_we    : m0_we;
    assign s_wbe        = w_sel ? m1_wbe   : m0_wbe;
    assign m0_req_ready = w_push && !w_sel;
    assign m1_req_ready = w_push &&  w_sel;

    assign w_s_resp_ready = !w_empty && (w_head ? m1_resp_ready : m0_resp_ready);
    assign w_pop          = s_resp_valid && w_s_resp_ready;
    assign s_resp_ready   = w_s_resp_ready;
    assign m0_resp_valid  = s_resp_valid && !w_empty && !w_head;
    assign m1_resp_valid  = s_resp_valid && !w_empty &&  w_head;
    assign m0_rdata       = s_rdata;
    assign m1_rdata       = s_rdata;

    // Lock FSM: pins the selection to a stalled master until it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OPEN:   if (w_s_req_valid && !s_req_ready) w_state_next = ST_LOCKED;
            ST_LOCKED: if (w_push)                        w_state_next = ST_OPEN;
            default:   w_state_next = ST_OPEN;
        endcase
    end

    always_comb begin
        w_locked = (r_state == ST_LOCKED);
    end

    // last_granted resets to m1 so that m0 wins the first contested cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_granted <= 1'b1;
            r_locked_id    <= 1'b0;
        end else begin
            if (w_push) begin
                r_last_granted <= w_sel;
            end
            if (w_s_req_valid && !s_req_ready) begin
                r_locked_id <= w_sel;
            end
        end
    end

    assign w_wr_ptr_next = (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_next = (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_resp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        s_resp_valid |-> !w_empty);

    a_m0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (m0_req_valid && !m0_req_ready) |=> (m0_req_valid && $stable(m0_addr) &&
        $stable(m0_wdata) && $stable(m0_we) && $stable(m0_wbe)));

    a_m1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (m1_req_valid && !m1_req_ready) |=> (m1_req_valid && $stable(m1_addr) &&
        $stable(m1_wdata) && $stable(m1_we) && $stable(m1_wbe)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Randomized scoreboard bench for sram_arbiter against a
//            transaction-level arbitration and routing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int OUTS = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [BW-1:0] wbe;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic [BW-1:0] m0_wbe = '0, m1_wbe = '0;
    logic          m0_req_valid = 1'b0, m1_req_valid = 1'b0;
    logic          m0_req_ready, m1_req_ready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_resp_valid, m1_resp_valid;
    logic          m0_resp_ready = 1'b0, m1_resp_ready = 1'b0;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_we;
    logic [BW-1:0] s_wbe;
    logic          s_req_valid;
    logic          s_req_ready = 1'b0;
    logic [DW-1:0] s_rdata = '0;
    logic          s_resp_valid = 1'b0;
    logic          s_resp_ready;

    sram_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .OUTSTANDING (OUTS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_we         (m0_we),
        .m0_wbe        (m0_wbe),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_rdata      (m0_rdata),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_ready (m0_resp_ready),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_we         (m1_we),
        .m1_wbe        (m1_wbe),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_rdata      (m1_rdata),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_ready (m1_resp_ready),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_we          (s_we),
        .s_wbe         (s_wbe),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_rdata       (s_rdata),
        .s_resp_valid  (s_resp_valid),
        .s_resp_ready  (s_resp_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int p_req0, p_req1, p_sready, p_resp, p_rr0, p_rr1;

    logic hs0 = 1'b0, hs1 = 1'b0, ds_pop = 1'b0;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    req_t          ds_q[$];

    // Downstream SRAM stand-in: the answer is a fixed function of the request.
    function automatic logic [DW-1:0] resp_fn(input req_t r);
        if (r.we) return r.wdata ^ 32'hFFFF_0000 ^ {28'd0, r.wbe};
        return (r.addr * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration rules applied to the visible inputs each cycle.
    initial begin : model
        logic last, lk, lk_id, sel, sv, can, rr, pop;
        logic ids[$];
        req_t r0, r1, rs;
        last = 1'b1; lk = 1'b0; lk_id = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_s_req_valid",   s_req_valid,   1'b0);
                check("rst_m0_req_ready",  m0_req_ready,  1'b0);
                check("rst_m1_req_ready",  m1_req_ready,  1'b0);
                check("rst_m0_resp_valid", m0_resp_valid, 1'b0);
                check("rst_m1_resp_valid", m1_resp_valid, 1'b0);
                check("rst_s_resp_ready",  s_resp_ready,  1'b0);
                last = 1'b1; lk = 1'b0; ids.delete();
                exp_q0.delete(); exp_q1.delete(); ds_q.delete();
                hs0 = 1'b0; hs1 = 1'b0; ds_pop = 1'b0;
                continue;
            end
            r0  = {m0_addr, m0_we, m0_wdata, m0_wbe};
            r1  = {m1_addr, m1_we, m1_wdata, m1_wbe};
            can = (ids.size() < OUTS);
            if (lk)                             sel = lk_id;
            else if (m0_req_valid && m1_req_valid) sel = ~last;
            else                                sel = m1_req_valid;
            sv = can && (sel ? m1_req_valid : m0_req_valid);
            check("s_req_valid",  s_req_valid,  sv);
            check("m0_req_ready", m0_req_ready, sv && s_req_ready && !sel);
            check("m1_req_ready", m1_req_ready, sv && s_req_ready &&  sel);
            if (sv) check("s_fields", {s_addr, s_we, s_wdata, s_wbe}, sel ? r1 : r0);

            rr  = (ids.size() > 0) ? (ids[0] ? m1_resp_ready : m0_resp_ready) : 1'b0;
            pop = s_resp_valid && rr;
            check("s_resp_ready",  s_resp_ready,  rr);
            check("m0_resp_valid", m0_resp_valid, s_resp_valid && ids.size() > 0 && !ids[0]);
            check("m1_resp_valid", m1_resp_valid, s_resp_valid && ids.size() > 0 &&  ids[0]);
            if (pop) void'(ids.pop_front());

            hs0 = sv && s_req_ready && !sel;
            hs1 = sv && s_req_ready &&  sel;
            if (sv && s_req_ready) begin
                if (sel) exp_q1.push_back(resp_fn(r1));
                else     exp_q0.push_back(resp_fn(r0));
                ids.push_back(sel);
                last = sel;
                lk   = 1'b0;
            end else if (sv) begin
                lk    = 1'b1;
                lk_id = sel;
            end

            if (s_req_valid && s_req_ready) begin
                rs = {s_addr, s_we, s_wdata, s_wbe};
                ds_q.push_back(rs);
            end
            ds_pop = s_resp_valid && s_resp_ready;
        end
    end

    // Response monitor: whatever a master accepts must be its next expected word.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m0_resp_valid && m0_resp_ready) begin
                    check("m0_resp_expected", exp_q0.size() > 0, 1'b1);
                    if (exp_q0.size() > 0) check("m0_rdata", m0_rdata, exp_q0.pop_front());
                end
                if (m1_resp_valid && m1_resp_ready) begin
                    check("m1_resp_expected", exp_q1.size() > 0, 1'b1);
                    if (exp_q1.size() > 0) check("m1_rdata", m1_rdata, exp_q1.pop_front());
                end
            end
        end
    end

    function automatic logic roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic drive();
        if (hs0) m0_req_valid = 1'b0;
        if (hs1) m1_req_valid = 1'b0;
        if (!m0_req_valid && roll(p_req0)) begin
            m0_req_valid = 1'b1;
            m0_addr = $urandom; m0_wdata = $urandom;
            m0_we = 1'($urandom); m0_wbe = 4'($urandom);
        end
        if (!m1_req_valid && roll(p_req1)) begin
            m1_req_valid = 1'b1;
            m1_addr = $urandom; m1_wdata = $urandom;
            m1_we = 1'($urandom); m1_wbe = 4'($urandom);
        end
        if (ds_pop) begin
            void'(ds_q.pop_front());
            s_resp_valid = 1'b0;
        end
        if (!s_resp_valid && ds_q.size() > 0 && roll(p_resp)) begin
            s_resp_valid = 1'b1;
            s_rdata      = resp_fn(ds_q[0]);
        end
        s_req_ready   = roll(p_sready);
        m0_resp_ready = roll(p_rr0);
        m1_resp_ready = roll(p_rr1);
    endtask

    task automatic run(input int cycles, input int q0, input int q1, input int sr,
                       input int rp, input int a0, input int a1);
        p_req0 = q0; p_req1 = q1; p_sready = sr; p_resp = rp; p_rr0 = a0; p_rr1 = a1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        s_resp_valid = 1'b0; s_req_ready = 1'b0;
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(20,  100,   0, 100, 100, 100, 100);   // m0 alone
        run(40,  100, 100, 100, 100, 100, 100);   // contention, alternation
        run(5,   100, 100,   0, 100, 100, 100);   // downstream stall -> lock
        run(10,  100, 100, 100, 100, 100, 100);
        run(12,  100, 100, 100,   0, 100, 100);   // fill routing FIFO
        run(10,  100, 100, 100, 100, 100, 100);
        run(15,  100, 100, 100, 100, 100,   0);   // m1 response back-pressure
        run(10,  100, 100, 100, 100, 100, 100);
        run(2000, 50,  50,  50,  50,  60,  60);
        run(10,  100, 100,  30,   0, 100, 100);   // build outstanding + lock
        do_reset(3);
        run(10,  100, 100, 100, 100, 100, 100);   // first contested grant is m0
        run(1000, 70,  40,  60,  40,  50,  80);
        run(40,    0,   0, 100, 100, 100, 100);   // drain

        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);
        check("ds_q_drained",   ds_q.size(),   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master, round-robin arbiter that sits directly upstream of the SRAM debouncer.
- Merges an instruction-fetch port (m0) and a data port (m1) into the single valid/ready request/response channel the debouncer accepts.
- Keeps an in-order routing FIFO of grant IDs so each response returns to the master that issued it.
- Holds the forwarded request stable from presentation until the downstream stage accepts it.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 wide.
- OUTSTANDING, 2, routing FIFO depth (max accepted-but-unanswered requests); power of two, >=1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_addr, m1_addr  in  ADDR_WIDTH  request address.
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data.
- m0_we, m1_we  in  1  write enable (1 = write).
- m0_wbe, m1_wbe  in  DATA_WIDTH/8  write byte enables.
- m0_req_valid, m1_req_valid  in  1  request valid.
- m0_req_ready, m1_req_ready  out  1  request accepted this cycle.
- m0_rdata, m1_rdata  out  DATA_WIDTH  response data.
- m0_resp_valid, m1_resp_valid  out  1  response valid.
- m0_resp_ready, m1_resp_ready  in  1  master accepts response.
- s_addr  out  ADDR_WIDTH  forwarded address.
- s_wdata  out  DATA_WIDTH  forwarded write data.
- s_we  out  1  forwarded write enable.
- s_wbe  out  DATA_WIDTH/8  forwarded byte enables.
- s_req_valid  out  1  forwarded request valid.
- s_req_ready  in  1  downstream accepts request.
- s_rdata  in  DATA_WIDTH  downstream response data.
- s_resp_valid  in  1  downstream response valid.
- s_resp_ready  out  1  arbiter accepts response.

Behaviour:
- Reset (rst_n low, async):
  - Routing FIFO empty, count 0.
  - Lock cleared; round-robin pointer favours m0.
  - All valid/ready outputs 0 while reset is asserted and in the first cycle after release if no inputs are valid.
  - Reset mid-transaction discards all in-flight routing state. Masters must also reset.
- Arbitration (combinational when unlocked):
  - can_issue = (count < OUTSTANDING), using the registered count only. A pop in the same cycle does not free a slot.
  - Only one master valid: that master is selected.
  - Both valid: select the master != last_granted.
  - last_granted updates only on an s_req handshake.
- Forwarding:
  - s_req_valid = can_issue && (selected master valid).
  - s_addr/s_wdata/s_we/s_wbe = selected master fields.
  - Non-selected master: req_ready = 0.
  - Selected master: req_ready = can_issue && s_req_ready.
- Lock:
  - If s_req_valid=1 and s_req_ready=0, register lock=1 and locked_id=selected.
  - While locked, selection is forced to locked_id regardless of the other master.
  - Lock clears on the handshake cycle. The request stays stable because masters are required to hold valid and fields until ready.
- Routing FIFO:
  - Push the granted ID on s_req_valid && s_req_ready.
  - Pop on s_resp_valid && s_resp_ready.
  - Simultaneous push and pop: count unchanged, pointers both advance.
  - Read and write pointers wrap modulo OUTSTANDING.
- Response routing (combinational):
  - head = FIFO head ID.
  - mX_resp_valid = s_resp_valid && !empty && head==X.
  - s_resp_ready = !empty && m[head]_resp_ready.
  - m0_rdata = m1_rdata = s_rdata (unconditional fan-out).
- Error conditions:
  - s_resp_valid with empty FIFO: s_resp_ready=0 and a simulation assertion fires.
  - A master changing fields while valid && !ready: simulation assertion.
- Latency:
  - Zero added cycles on the request path; grant is combinational.
  - Zero added cycles on the response path.
  - Throughput: one request per cycle, limited by the downstream stage and OUTSTANDING.

Test Plan:
- Only m0 valid, addr 0x100, read; s_req_ready=1 → s_addr=0x100, m0_req_ready=1 same cycle; response 0xDEADBEEF later → m0_resp_valid=1, m1_resp_valid=0.
- Both valid every cycle, s_req_ready=1, responses returned in order → grants alternate m0,m1,m0,m1, and each response lands on its issuer.
- Both valid, m1 last granted, s_req_ready=0 for 3 cycles → m0 locked; s_* stable all 3 cycles; m1_req_ready=0 throughout; m0 accepted on the 4th cycle.
- OUTSTANDING=2, issue 2 requests with no responses → third request sees s_req_valid=0. Return 1 response → issue resumes the following cycle.
- Response arrives with m1_resp_ready=0 for 2 cycles → s_resp_ready=0 for 2 cycles, FIFO not popped, pop on the 3rd cycle.
- rst_n pulsed low with 2 outstanding and a locked request → FIFO empty, s_req_valid=0, the next grant goes to m0 when both are valid.
